uart_loader: RTL and testbench

- Boot-load controller that sequences the serial receiver's byte stream into the instruction/data memory, then releases the CPU.
- Sits between uart_rx (data, data_ready) and the memory write port.
- Owns the CPU run enable: holds the core stalled until a framed, checksummed image has been written.

---
 rtl/uart_loader.sv | 149 ++++++++++++++
 tb/tb_uart_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Boot loader: frames uart_rx bytes into 16-bit memory writes, checks sum, releases CPU.
// Ports: clk, rst(sync, low), rx_data/rx_ready in; mem_addr/mem_data/mem_we, cpu_run, busy, load_error out.
module uart_loader #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BASE_ADDR    = 0,
  parameter int TIMEOUT_CLKS = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_we,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  load_error
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_SUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_ready_q;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [7:0]            lo_q, lo_d;
  logic [15:0]           rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  strobe;
  logic                  busy_s;

  // Rising edge of the ready level is one byte.
  assign strobe = rx_ready & ~rx_ready_q;

  assign busy_s = (state_q == S_CNT_HI) || (state_q == S_DATA_LO) ||
                  (state_q == S_DATA_HI) || (state_q == S_SUM);

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_lo_d   = cnt_lo_q;
    lo_d       = lo_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;

    if (reload) begin
      state_d = S_CNT_LO;
      sum_d   = '0;
      idx_d   = '0;
      tmo_d   = '0;
    end else if (strobe) begin
      tmo_d = '0;
      unique case (state_q)
        S_CNT_LO: begin
          cnt_lo_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = S_CNT_HI;
        end
        S_CNT_HI: begin
          rem_d   = {rx_data, cnt_lo_q};
          sum_d   = sum_q + rx_data;
          state_d = ({rx_data, cnt_lo_q} == 16'd0) ? S_SUM : S_DATA_LO;
        end
        S_DATA_LO: begin
          lo_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          mem_we_d   = 1'b1;
          mem_data_d = {rx_data, lo_q};
          mem_addr_d = BASE + idx_q;
          idx_d      = idx_q + 1'b1;
          rem_d      = rem_q - 16'd1;
          sum_d      = sum_q + rx_data;
          state_d    = (rem_q == 16'd1) ? S_SUM : S_DATA_LO;
        end
        S_SUM: begin
          state_d = (rx_data == sum_q) ? S_RUN : S_ERR;
        end
        default: ;
      endcase
    end else if (busy_s) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_ERR;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CNT_LO;
      rx_ready_q <= 1'b1;
      sum_q      <= '0;
      cnt_lo_q   <= '0;
      lo_q       <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      mem_addr_q <= BASE;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;
      sum_q      <= sum_d;
      cnt_lo_q   <= cnt_lo_d;
      lo_q       <= lo_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign cpu_run    = (state_q == S_RUN);
  assign load_error = (state_q == S_ERR);
  assign busy       = busy_s;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: base 0 / timeout 100 unit plus
// base 0xFFFF / timeout 1000 unit driven by the same byte stream.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;

  logic [15:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_we, b_we, a_run, b_run, a_busy, b_busy, a_err, b_err;

  int errors = 0;
  int checks = 0;
  int a_wr = 0;

  logic        we1_a, we1_b, we2_a;
  logic [15:0] ad1_a, ad1_b, dt1_a;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_WIDTH(16), .BASE_ADDR(0), .TIMEOUT_CLKS(100)) u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .mem_addr(a_addr), .mem_data(a_data), .mem_we(a_we),
    .cpu_run(a_run), .busy(a_busy), .load_error(a_err)
  );

  uart_loader #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF), .TIMEOUT_CLKS(1000)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .mem_addr(b_addr), .mem_data(b_data), .mem_we(b_we),
    .cpu_run(b_run), .busy(b_busy), .load_error(b_err)
  );

  always @(negedge clk) if (a_we === 1'b1) a_wr++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte: ready rises at a negedge, strobe edge, then one low cycle.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    we1_a = a_we; ad1_a = a_addr; dt1_a = a_data;
    we1_b = b_we; ad1_b = b_addr;
    @(negedge clk);
    rx_ready = 1'b0;
    @(posedge clk); #1;
    we2_a = a_we;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int w0;
    rst = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", a_addr, 16'h0000);
    chk("rst_addr_b", b_addr, 16'hFFFF);
    chk("rst_data", a_data, 16'h0000);
    chk("rst_flags", {a_we, a_run, a_busy, a_err}, 4'b0000);
    @(negedge clk); rst = 1'b1;

    // Normal load
    send(8'h02); chk("n_busy", a_busy, 1'b1);
    send(8'h00);
    send(8'h34); chk("n_lo_nowe", we1_a, 1'b0);
    send(8'h12);
    chk("n_w0", {we1_a, ad1_a, dt1_a}, {1'b1, 16'h0000, 16'h1234});
    chk("n_w0_b", {we1_b, ad1_b}, {1'b1, 16'hFFFF});
    chk("n_w0_pulse", we2_a, 1'b0);
    send(8'hCD);
    send(8'hAB);
    chk("n_w1", {we1_a, ad1_a, dt1_a}, {1'b1, 16'h0001, 16'hABCD});
    chk("n_w1_b", {we1_b, ad1_b}, {1'b1, 16'h0000});
    chk("n_hold", {a_addr, a_data}, {16'h0001, 16'hABCD});
    send(8'hC0);
    chk("n_run", {a_run, a_err, a_busy}, 3'b100);
    chk("n_wcnt", a_wr, 2);

    // Bad checksum
    do_reset;
    w0 = a_wr;
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    send(8'hCD); send(8'hAB); send(8'hC1);
    chk("bad_flags", {a_run, a_err}, 2'b01);
    chk("bad_wcnt", a_wr - w0, 2);
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    chk("bad_ignore", a_wr - w0, 2);
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    chk("bad_reload", {a_err, a_busy, a_run}, 3'b000);

    // Empty image, with ready high across reset release
    @(negedge clk); rst = 1'b0; rx_data = 8'h00; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("stale_ready", a_busy, 1'b0);
    @(negedge clk); rx_ready = 1'b0;
    w0 = a_wr;
    send(8'h00); send(8'h00); send(8'h00);
    chk("empty_run", {a_run, a_err}, 2'b10);
    chk("empty_nowe", a_wr - w0, 0);

    // Timeout, and no timeout before the first byte
    do_reset;
    repeat (300) @(posedge clk);
    #1 chk("idle_noerr", {a_err, a_busy}, 2'b00);
    @(negedge clk); rx_data = 8'h02; rx_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rx_ready = 1'b0;
    repeat (99) @(posedge clk);
    #1 chk("tmo_99", a_err, 1'b0);
    @(posedge clk);
    #1 chk("tmo_100", {a_err, a_busy}, 2'b10);

    // Level held high 200 cycles is one byte (unit b, long timeout)
    do_reset;
    @(negedge clk); rx_data = 8'h00; rx_ready = 1'b1;
    repeat (200) @(posedge clk);
    #1 chk("held_one", {b_busy, b_run, b_err}, 3'b100);
    @(negedge clk); rx_ready = 1'b0;
    send(8'h00); send(8'h00);
    chk("held_run", b_run, 1'b1);

    // Reload coincident with a strobe discards the byte
    do_reset;
    send(8'h02); send(8'h00);
    @(negedge clk); rx_data = 8'h34; rx_ready = 1'b1; reload = 1'b1;
    @(posedge clk); #1;
    chk("rl_discard", a_busy, 1'b0);
    @(negedge clk); reload = 1'b0; rx_ready = 1'b0;
    w0 = a_wr;
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    chk("rl_w", {we1_a, ad1_a, dt1_a}, {1'b1, 16'h0000, 16'h2211});
    send(8'h34);
    chk("rl_run", {a_run, a_err}, 2'b10);
    chk("rl_wcnt", a_wr - w0, 1);

    // Reset mid-frame
    do_reset;
    send(8'h02); send(8'h00); send(8'h34);
    w0 = a_wr;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst", {a_we, a_run, a_busy, a_err, a_addr, a_data},
        {4'b0000, 16'h0000, 16'h0000});
    @(negedge clk); rst = 1'b1;
    chk("mid_nowe", a_wr - w0, 0);
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    chk("mid_w0", {we1_a, ad1_a, dt1_a}, {1'b1, 16'h0000, 16'h1234});
    send(8'hCD); send(8'hAB);
    chk("mid_w1", {we1_a, ad1_a, dt1_a}, {1'b1, 16'h0001, 16'hABCD});
    send(8'hC0);
    chk("mid_run", {a_run, a_err}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
